// File: rtl/aes_host_ahb_master.sv
// AHB-Lite initiator that programs the AES slave (KEY, NONCE, DEST) and then streams plaintext.
// Define AES_HOST_BURST_EN to issue each 128-bit write as one INCR4 burst instead of four SINGLEs.
module aes_host_ahb_master #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] KEY_OFF   = 32'h0000_0000,
  parameter logic [31:0] NONCE_OFF = 32'h0000_0010,
  parameter logic [31:0] DEST_OFF  = 32'h0000_0020,
  parameter logic [31:0] PT_OFF    = 32'h0000_0030
) (
  input  logic         HCLK,
  input  logic         HRESET,
  input  logic         start,
  input  logic         stop,
  input  logic [127:0] key,
  input  logic [127:0] nonce,
  input  logic [31:0]  dest,
  input  logic         pt_valid,
  input  logic [127:0] pt_data,
  output logic         pt_ready,
  input  logic         HREADY,
  input  logic         HRESP,
  output logic [31:0]  HADDR,
  output logic         HWRITE,
  output logic [2:0]   HSIZE,
  output logic [2:0]   HBURST,
  output logic [1:0]   HTRANS,
  output logic [31:0]  HWDATA,
  output logic         busy,
  output logic         cfg_done,
  output logic         err
);

  localparam logic [1:0] TransIdle   = 2'b00;
  localparam logic [1:0] TransNonseq = 2'b10;
  localparam logic [1:0] TransSeq    = 2'b11;
  localparam logic [2:0] BurstSingle = 3'b000;
  localparam logic [2:0] BurstIncr4  = 3'b011;

  typedef enum logic [2:0] {StIdle, StKey, StNonce, StDest, StStream, StPtWr, StErr} state_e;

  state_e         state_q, state_d, cfg_state;
  logic [3:0]     cnt_q, cnt_d;
  logic [127:0]   key_q, key_d, nonce_q, nonce_d, pt_q, pt_d;
  logic [31:0]    dest_q, dest_d;
  logic           stop_q, stop_d, dpend_q, dpend_d;
  logic [31:0]    apdata_q, apdata_d, haddr_q, haddr_d, hwdata_q, hwdata_d;
  logic [1:0]     htrans_q, htrans_d;
  logic [2:0]     hburst_q, hburst_d;
  logic           hwrite_q, hwrite_d, cfg_done_q, cfg_done_d, err_q, err_d;

  logic [127:0]   key_src, nonce_src, pt_src;
  logic [31:0]    word_off, cfg_addr, cfg_data, pt_addr, pt_word;
  logic [1:0]     grp_trans, cfg_trans;
  logic [2:0]     grp_burst, cfg_burst;

  function automatic logic [31:0] word_sel(input logic [127:0] blk, input logic [1:0] idx);
    case (idx)
      2'd0:    word_sel = blk[31:0];
      2'd1:    word_sel = blk[63:32];
      2'd2:    word_sel = blk[95:64];
      default: word_sel = blk[127:96];
    endcase
  endfunction

  // Fields of the beat with index cnt_q; the first beat is taken straight from the inputs.
  always_comb begin
    key_src   = (state_q == StIdle) ? key : key_q;
    nonce_src = (state_q == StIdle) ? nonce : nonce_q;
    pt_src    = (state_q == StStream) ? pt_data : pt_q;
    word_off  = {28'd0, cnt_q[1:0], 2'b00};
`ifdef AES_HOST_BURST_EN
    grp_trans = (cnt_q[1:0] == 2'd0) ? TransNonseq : TransSeq;
    grp_burst = BurstIncr4;
`else
    grp_trans = TransNonseq;
    grp_burst = BurstSingle;
`endif
    cfg_trans = grp_trans;
    cfg_burst = grp_burst;
    if (cnt_q < 4'd4) begin
      cfg_addr  = BASE_ADDR + KEY_OFF + word_off;
      cfg_data  = word_sel(key_src, cnt_q[1:0]);
      cfg_state = StKey;
    end else if (cnt_q < 4'd8) begin
      cfg_addr  = BASE_ADDR + NONCE_OFF + word_off;
      cfg_data  = word_sel(nonce_src, cnt_q[1:0]);
      cfg_state = StNonce;
    end else begin
      cfg_addr  = BASE_ADDR + DEST_OFF;
      cfg_data  = (state_q == StIdle) ? dest : dest_q;
      cfg_trans = TransNonseq;
      cfg_burst = BurstSingle;
      cfg_state = StDest;
    end
    pt_addr = BASE_ADDR + PT_OFF + word_off;
    pt_word = word_sel(pt_src, cnt_q[1:0]);
  end

  assign pt_ready = (state_q == StStream) && !dpend_q && !stop;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    key_d      = key_q;
    nonce_d    = nonce_q;
    dest_d     = dest_q;
    pt_d       = pt_q;
    stop_d     = stop_q;
    dpend_d    = dpend_q;
    apdata_d   = apdata_q;
    haddr_d    = haddr_q;
    htrans_d   = htrans_q;
    hburst_d   = hburst_q;
    hwdata_d   = hwdata_q;
    cfg_done_d = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      StIdle: begin
        stop_d = 1'b0;
        if (start) begin
          key_d    = key;
          nonce_d  = nonce;
          dest_d   = dest;
          haddr_d  = cfg_addr;
          apdata_d = cfg_data;
          htrans_d = cfg_trans;
          hburst_d = cfg_burst;
          cnt_d    = 4'd1;
          state_d  = StKey;
        end
      end
      StKey, StNonce, StDest: begin
        if (HREADY) begin
          dpend_d = (htrans_q != TransIdle);
          if (htrans_q != TransIdle) hwdata_d = apdata_q;
          if (cnt_q < 4'd9) begin
            haddr_d  = cfg_addr;
            apdata_d = cfg_data;
            htrans_d = cfg_trans;
            hburst_d = cfg_burst;
            cnt_d    = cnt_q + 4'd1;
            state_d  = cfg_state;
          end else begin
            htrans_d = TransIdle;
            hburst_d = BurstSingle;
            if (htrans_q == TransIdle && dpend_q) begin
              cfg_done_d = 1'b1;
              cnt_d      = 4'd0;
              state_d    = StStream;
            end
          end
        end
      end
      StStream: begin
        if (stop) begin
          state_d = StIdle;
        end else if (pt_valid && pt_ready) begin
          pt_d     = pt_data;
          haddr_d  = pt_addr;
          apdata_d = pt_word;
          htrans_d = grp_trans;
          hburst_d = grp_burst;
          cnt_d    = 4'd1;
          state_d  = StPtWr;
        end
      end
      StPtWr: begin
        if (stop) stop_d = 1'b1;
        if (HREADY) begin
          dpend_d = (htrans_q != TransIdle);
          if (htrans_q != TransIdle) hwdata_d = apdata_q;
          if (cnt_q < 4'd4) begin
            haddr_d  = pt_addr;
            apdata_d = pt_word;
            htrans_d = grp_trans;
            hburst_d = grp_burst;
            cnt_d    = cnt_q + 4'd1;
          end else begin
            htrans_d = TransIdle;
            hburst_d = BurstSingle;
            if (htrans_q == TransIdle && dpend_q) begin
              cnt_d   = 4'd0;
              stop_d  = 1'b0;
              state_d = (stop_q || stop) ? StIdle : StStream;
            end
          end
        end
      end
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // First ERROR response cycle: cancel the beat in its address phase.
    if (dpend_q && HRESP && !HREADY) begin
      htrans_d = TransIdle;
      hburst_d = BurstSingle;
      dpend_d  = 1'b0;
      cnt_d    = 4'd0;
      stop_d   = 1'b0;
      err_d    = 1'b1;
      state_d  = StErr;
    end
    hwrite_d = (htrans_d != TransIdle);
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      key_q      <= '0;
      nonce_q    <= '0;
      dest_q     <= '0;
      pt_q       <= '0;
      stop_q     <= 1'b0;
      dpend_q    <= 1'b0;
      apdata_q   <= '0;
      haddr_q    <= '0;
      htrans_q   <= TransIdle;
      hburst_q   <= BurstSingle;
      hwrite_q   <= 1'b0;
      hwdata_q   <= '0;
      cfg_done_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      key_q      <= key_d;
      nonce_q    <= nonce_d;
      dest_q     <= dest_d;
      pt_q       <= pt_d;
      stop_q     <= stop_d;
      dpend_q    <= dpend_d;
      apdata_q   <= apdata_d;
      haddr_q    <= haddr_d;
      htrans_q   <= htrans_d;
      hburst_q   <= hburst_d;
      hwrite_q   <= hwrite_d;
      hwdata_q   <= hwdata_d;
      cfg_done_q <= cfg_done_d;
      err_q      <= err_d;
    end
  end

  assign HADDR    = haddr_q;
  assign HWRITE   = hwrite_q;
  assign HSIZE    = 3'b010;
  assign HBURST   = hburst_q;
  assign HTRANS   = htrans_q;
  assign HWDATA   = hwdata_q;
  assign busy     = (state_q != StIdle);
  assign cfg_done = cfg_done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_aes_host_ahb_master.sv
// Directed bench for aes_host_ahb_master: a bus monitor logs completed write beats, which are
// compared against hand-computed tables; multi-cycle corners are hand-written sequences.
module tb_aes_host_ahb_master;

  logic         HCLK = 1'b0;
  logic         HRESET, start, stop, pt_valid, HREADY, HRESP;
  logic [127:0] key, nonce, pt_data;
  logic [31:0]  dest;
  logic         pt_ready, HWRITE, busy, cfg_done, err;
  logic [31:0]  HADDR, HWDATA;
  logic [2:0]   HSIZE, HBURST;
  logic [1:0]   HTRANS;

  aes_host_ahb_master dut (
    .HCLK(HCLK), .HRESET(HRESET), .start(start), .stop(stop), .key(key), .nonce(nonce),
    .dest(dest), .pt_valid(pt_valid), .pt_data(pt_data), .pt_ready(pt_ready), .HREADY(HREADY),
    .HRESP(HRESP), .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
    .HTRANS(HTRANS), .HWDATA(HWDATA), .busy(busy), .cfg_done(cfg_done), .err(err)
  );

  always #5 HCLK = ~HCLK;

`ifdef AES_HOST_BURST_EN
  localparam logic [1:0] TrNext = 2'b11;
  localparam logic [2:0] BuGrp  = 3'b011;
`else
  localparam logic [1:0] TrNext = 2'b10;
  localparam logic [2:0] BuGrp  = 3'b000;
`endif
  localparam logic [1:0] TrFirst = 2'b10;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  tr;
    logic [2:0]  bu;
  } beat_t;

  beat_t cfg_tab[9];
  beat_t pt_tab[8];

  int nchk = 0, nerr = 0, cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  // Bus monitor: a beat is logged when its data phase completes without ERROR.
  logic        dp_v = 1'b0;
  logic [31:0] dp_a = '0;
  logic [1:0]  dp_tr = '0;
  logic [2:0]  dp_bu = '0;
  logic [31:0] log_a[128], log_d[128];
  logic [1:0]  log_tr[128];
  logic [2:0]  log_bu[128];
  int          log_c[128];
  int          nlog = 0, nerrp = 0, nrdy = 0, ntr = 0;

  always @(negedge HCLK) begin
    if (HRESET) begin
      dp_v <= 1'b0;
    end else begin
      if (dp_v && HREADY && !HRESP && nlog < 128) begin
        log_a[nlog]  <= dp_a;
        log_d[nlog]  <= HWDATA;
        log_tr[nlog] <= dp_tr;
        log_bu[nlog] <= dp_bu;
        log_c[nlog]  <= cyc;
        nlog         <= nlog + 1;
      end
      if (HREADY) begin
        dp_v  <= (HTRANS != 2'b00);
        dp_a  <= HADDR;
        dp_tr <= HTRANS;
        dp_bu <= HBURST;
      end
    end
    if (err) nerrp <= nerrp + 1;
    if (pt_ready) nrdy <= nrdy + 1;
    if (HTRANS != 2'b00) ntr <= ntr + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_start(output int s);
    start = 1'b1;
    s = cyc;
    step();
    start = 1'b0;
  endtask

  task automatic wait_cfg(input string name);
    logic found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (cfg_done) found = 1'b1;
      else step();
    end
    check(name, {31'd0, found}, 32'd1);
  endtask

  task automatic wait_addr(input logic [31:0] a, input string name);
    logic found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (HTRANS != 2'b00 && HADDR == a) found = 1'b1;
      else step();
    end
    check(name, {31'd0, found}, 32'd1);
  endtask

  task automatic wait_hs(input string name);
    logic found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (pt_ready && pt_valid) found = 1'b1;
      else step();
    end
    check(name, {31'd0, found}, 32'd1);
  endtask

  task automatic wait_idle(input string name);
    logic found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (!busy) found = 1'b1;
      else step();
    end
    check(name, {31'd0, found}, 32'd1);
  endtask

  task automatic check_beat(input string name, input int idx, input beat_t e);
    check({name, "_addr"}, log_a[idx], e.addr);
    check({name, "_data"}, log_d[idx], e.data);
    check({name, "_htrans"}, {30'd0, log_tr[idx]}, {30'd0, e.tr});
    check({name, "_hburst"}, {29'd0, log_bu[idx]}, {29'd0, e.bu});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, base, r0, e0, t, hs2;
    logic [31:0] c_words[4];
    c_words = '{32'hC0C0C0C0, 32'hC1C1C1C1, 32'hC2C2C2C2, 32'hC3C3C3C3};

    cfg_tab[0] = '{32'h00, 32'hCCDDEEFF, TrFirst, BuGrp};
    cfg_tab[1] = '{32'h04, 32'h8899AABB, TrNext,  BuGrp};
    cfg_tab[2] = '{32'h08, 32'h44556677, TrNext,  BuGrp};
    cfg_tab[3] = '{32'h0C, 32'h00112233, TrNext,  BuGrp};
    cfg_tab[4] = '{32'h10, 32'h03020100, TrFirst, BuGrp};
    cfg_tab[5] = '{32'h14, 32'h07060504, TrNext,  BuGrp};
    cfg_tab[6] = '{32'h18, 32'h0B0A0908, TrNext,  BuGrp};
    cfg_tab[7] = '{32'h1C, 32'h0F0E0D0C, TrNext,  BuGrp};
    cfg_tab[8] = '{32'h20, 32'hDEADBEEF, 2'b10,   3'b000};
    pt_tab[0]  = '{32'h30, 32'hA0A0A0A0, TrFirst, BuGrp};
    pt_tab[1]  = '{32'h34, 32'hA1A1A1A1, TrNext,  BuGrp};
    pt_tab[2]  = '{32'h38, 32'hA2A2A2A2, TrNext,  BuGrp};
    pt_tab[3]  = '{32'h3C, 32'hA3A3A3A3, TrNext,  BuGrp};
    pt_tab[4]  = '{32'h30, 32'hB0B0B0B0, TrFirst, BuGrp};
    pt_tab[5]  = '{32'h34, 32'hB1B1B1B1, TrNext,  BuGrp};
    pt_tab[6]  = '{32'h38, 32'hB2B2B2B2, TrNext,  BuGrp};
    pt_tab[7]  = '{32'h3C, 32'hB3B3B3B3, TrNext,  BuGrp};

    HRESET = 1'b1; start = 1'b0; stop = 1'b0; pt_valid = 1'b0; HREADY = 1'b1; HRESP = 1'b0;
    key     = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    nonce   = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
    dest    = 32'hDEADBEEF;
    pt_data = '0;
    cycles(3);

    check("rst_htrans", {30'd0, HTRANS}, 32'd0);
    check("rst_haddr", HADDR, 32'd0);
    check("rst_hwrite", {31'd0, HWRITE}, 32'd0);
    check("rst_hsize", {29'd0, HSIZE}, 32'd2);
    check("rst_hburst", {29'd0, HBURST}, 32'd0);
    check("rst_hwdata", HWDATA, 32'd0);
    check("rst_pt_ready", {31'd0, pt_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_cfg_done", {31'd0, cfg_done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    HRESET = 1'b0;
    step();

    // Reset in the middle of KEY beat 2.
    do_start(s);
    wait_addr(32'h04, "midrst_reach_key2");
    HRESET = 1'b1;
    step();
    HRESET = 1'b0;
    check("midrst_htrans", {30'd0, HTRANS}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_haddr", HADDR, 32'd0);
    check("midrst_hwrite", {31'd0, HWRITE}, 32'd0);
    t = ntr;
    cycles(5);
    check("midrst_no_beats", ntr - t, 32'd0);

    // Configuration with zero wait states.
    base = nlog;
    do_start(s);
    check("cfg_busy", {31'd0, busy}, 32'd1);
    wait_cfg("cfg_done_seen");
    check("cfg_nbeats", nlog - base, 32'd9);
    for (int i = 0; i < 9; i++) check_beat($sformatf("cfg%0d", i), base + i, cfg_tab[i]);
    check("cfg_latency", cyc - s, 32'd11);
    check("cfg_done_after_last", cyc, log_c[base + 8] + 1);

    // Two back-to-back plaintext blocks, then a third stopped mid-block.
    pt_valid = 1'b1;
    pt_data  = 128'hA3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
    base = nlog;
    r0 = nrdy;
    wait_hs("hs1_seen");
    step();
    pt_data = 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0;
    check("cfg_done_pulse", {31'd0, cfg_done}, 32'd0);
    wait_hs("hs2_seen");
    hs2 = cyc;
    check("hs2_back_to_back", hs2, log_c[base + 3] + 1);
    step();
    pt_data = 128'hC3C3C3C3_C2C2C2C2_C1C1C1C1_C0C0C0C0;
    wait_hs("hs3_seen");
    check("pt_nbeats", nlog - base, 32'd8);
    for (int i = 0; i < 8; i++) check_beat($sformatf("pt%0d", i), base + i, pt_tab[i]);
    check("pt_ready_pulses", nrdy - r0, 32'd2);
    step();
    check("stop_beat1_addr", HADDR, 32'h30);
    stop = 1'b1;
    step();
    stop = 1'b0;
    wait_idle("stop_idle_seen");
    check("stop_nbeats", nlog - (base + 8), 32'd4);
    for (int j = 0; j < 4; j++) begin
      check($sformatf("stop%0d_addr", j), log_a[base + 8 + j], 32'h30 + 32'(4 * j));
      check($sformatf("stop%0d_data", j), log_d[base + 8 + j], c_words[j]);
    end
    cycles(2);
    check("stop_pt_ready", {31'd0, pt_ready}, 32'd0);
    check("stop_busy", {31'd0, busy}, 32'd0);
    check("stop_ready_count", nrdy - r0, 32'd3);
    pt_valid = 1'b0;
    step();

    // Three wait states on NONCE beat 1.
    do_start(s);
    wait_addr(32'h14, "ws_reach_nonce1");
    HREADY = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("ws%0d_haddr", k), HADDR, 32'h14);
      check($sformatf("ws%0d_hwdata", k), HWDATA, 32'h03020100);
      step();
    end
    HREADY = 1'b1;
    wait_cfg("ws_cfg_done_seen");
    check("ws_latency", cyc - s, 32'd14);

    // stop and pt_valid together in STREAM: stop wins.
    t = nlog;
    pt_valid = 1'b1;
    stop = 1'b1;
    #1;
    check("stopwin_pt_ready", {31'd0, pt_ready}, 32'd0);
    step();
    stop = 1'b0;
    pt_valid = 1'b0;
    check("stopwin_busy", {31'd0, busy}, 32'd0);
    cycles(2);
    check("stopwin_no_beats", nlog - t, 32'd0);

    // ERROR response on plaintext beat 2.
    do_start(s);
    wait_cfg("err_cfg_done_seen");
    base = nlog;
    e0 = nerrp;
    pt_valid = 1'b1;
    pt_data = 128'hD3D3D3D3_D2D2D2D2_D1D1D1D1_D0D0D0D0;
    wait_hs("err_hs_seen");
    step();
    pt_valid = 1'b0;
    wait_addr(32'h38, "err_reach_beat3");
    HRESP = 1'b1;
    HREADY = 1'b0;
    step();
    check("err_htrans", {30'd0, HTRANS}, 32'd0);
    check("err_pulse", {31'd0, err}, 32'd1);
    HREADY = 1'b1;
    step();
    HRESP = 1'b0;
    check("err_idle", {31'd0, busy}, 32'd0);
    check("err_pulse_end", {31'd0, err}, 32'd0);
    t = ntr;
    cycles(4);
    check("err_no_beats", ntr - t, 32'd0);
    check("err_pulse_count", nerrp - e0, 32'd1);
    check("err_nbeats", nlog - base, 32'd1);
    check("err_beat0_addr", log_a[base], 32'h30);
    check("err_beat0_data", log_d[base], 32'hD0D0D0D0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
